// File: rtl/div_seq_pkg.sv
// Shared encodings for the EX-stage iterative divider.
package div_seq_pkg;

   // Sequencer states.
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Result-valid encodings.
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // Start-request encodings.
   localparam logic DivStart = 1'b1;
   localparam logic DivStop  = 1'b0;

   // The pipeline must be held in every state except END, where the result is
   // handed over and EX is allowed to advance.
   function automatic logic div_needs_hold(div_state_e state);
      return state != DivEnd;
   endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring shift-subtract step: subtract the divisor from the shifted partial
// remainder and keep the difference only when it does not go negative.
module div_seq_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_bit_o
);

   logic [WIDTH+1:0] diff;

   // One extra bit on top of the subtraction acts as the borrow / sign flag.
   always_comb begin
      diff    = {1'b0, rem_i} - {2'b00, divisor_i};
      q_bit_o = ~diff[WIDTH+1];
      rem_o   = q_bit_o ? diff[WIDTH:0] : rem_i;
   end

endmodule

// File: rtl/div_seq.sv
// Iterative DIV/DIVU sequencer for EX: one quotient bit per cycle, stalls the
// pipeline while busy and presents {remainder, quotient} for one cycle when done.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stallreq_o
);

   localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   div_state_e         state_q;
   logic [CntW-1:0]    cnt_q;
   // {partial remainder (WIDTH+1 bits), dividend bits shifting out / quotient in}
   logic [2*WIDTH:0]   work_q;
   logic [WIDTH-1:0]   divisor_q;
   logic               neg_dividend_q;
   logic               neg_divisor_q;
   logic [2*WIDTH-1:0] result_q;
   logic               ready_q;

   logic [WIDTH-1:0]   op1_abs;
   logic [WIDTH-1:0]   op2_abs;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     step_rem;
   logic               step_q_bit;
   logic [2*WIDTH:0]   next_work;
   logic [WIDTH-1:0]   quot_raw;
   logic [WIDTH-1:0]   rem_raw;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   // The remainder never reaches the top bit of its field; keep lint quiet about it.
   logic unused_rem_msb;
   assign unused_rem_msb = work_q[2*WIDTH];

   // Operand magnitudes; absolute value only for signed divides.
   always_comb begin
      op1_abs = opdata1_i;
      op2_abs = opdata2_i;
      if (signed_div_i && opdata1_i[WIDTH-1]) begin
         op1_abs = -opdata1_i;
      end
      if (signed_div_i && opdata2_i[WIDTH-1]) begin
         op2_abs = -opdata2_i;
      end
   end

   // Shift the next dividend bit into the partial remainder ahead of the trial subtract.
   always_comb begin
      rem_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   end

   div_seq_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i     (rem_shift),
      .divisor_i (divisor_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_q_bit)
   );

   // Next working register and the sign-corrected result of the final iteration.
   always_comb begin
      next_work = {step_rem, work_q[WIDTH-2:0], step_q_bit};
      quot_raw  = next_work[WIDTH-1:0];
      rem_raw   = step_rem[WIDTH-1:0];
      quot_fix  = (neg_dividend_q ^ neg_divisor_q) ? -quot_raw : quot_raw;
      rem_fix   = neg_dividend_q ? -rem_raw : rem_raw;
   end

   // Sequencer FSM with registered result and ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= DivFree;
         cnt_q          <= '0;
         work_q         <= '0;
         divisor_q      <= '0;
         neg_dividend_q <= 1'b0;
         neg_divisor_q  <= 1'b0;
         result_q       <= '0;
         ready_q        <= DivResultNotReady;
      end else if (annul_i) begin
         state_q  <= DivFree;
         cnt_q    <= '0;
         result_q <= '0;
         ready_q  <= DivResultNotReady;
      end else begin
         unique case (state_q)
            DivFree: begin
               result_q <= '0;
               ready_q  <= DivResultNotReady;
               if (start_i == DivStart) begin
                  if (opdata2_i == '0) begin
                     state_q <= DivByZero;
                  end else begin
                     state_q        <= DivOn;
                     cnt_q          <= '0;
                     work_q         <= {{(WIDTH+1){1'b0}}, op1_abs};
                     divisor_q      <= op2_abs;
                     neg_dividend_q <= signed_div_i & opdata1_i[WIDTH-1];
                     neg_divisor_q  <= signed_div_i & opdata2_i[WIDTH-1];
                  end
               end
            end
            DivByZero: begin
               state_q  <= DivEnd;
               result_q <= '0;
               ready_q  <= DivResultReady;
            end
            DivOn: begin
               work_q <= next_work;
               cnt_q  <= cnt_q + CntOne;
               if (cnt_q == CntLast) begin
                  state_q  <= DivEnd;
                  result_q <= {rem_fix, quot_fix};
                  ready_q  <= DivResultReady;
               end
            end
            DivEnd: begin
               state_q  <= DivFree;
               result_q <= '0;
               ready_q  <= DivResultNotReady;
            end
            default: begin
               state_q  <= DivFree;
               result_q <= '0;
               ready_q  <= DivResultNotReady;
            end
         endcase
      end
   end

   // Outputs: result and ready are registered, the stall request is combinational.
   always_comb begin
      result_o   = result_q;
      ready_o    = ready_q;
      stallreq_o = (start_i == DivStart) & ~annul_i & div_needs_hold(state_q);
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: stall length, result values, divide by zero,
// annul, mid-operation reset and operand changes while busy.
module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int checks;
   int failures;

   div_seq #(
      .WIDTH (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drives a divide from the current cycle (C0) and runs until ready_o or a
   // cycle budget expires; returns in the END cycle with start_i still driven.
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_stall,
                         input logic scramble);
      int stalls;
      int cyc;
      stalls = 0;
      cyc    = 0;
      start_i      = 1'b1;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      #1;
      while (ready_o !== 1'b1 && cyc < 45) begin
         if (stallreq_o === 1'b1) stalls++;
         next_cycle();
         cyc++;
         if (scramble && cyc == 5) begin
            opdata1_i    = 32'h1234_5678;
            opdata2_i    = 32'h0;
            signed_div_i = ~sgn;
         end
      end
      check({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
      check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
      check({tag, "_result"}, result_o, exp);
      check({tag, "_stall_end"}, {63'd0, stallreq_o}, 64'd0);
   endtask

   // Checks the FREE cycle that follows END.
   task automatic check_free(input string tag);
      next_cycle();
      check({tag, "_free_ready"}, {63'd0, ready_o}, 64'd0);
      check({tag, "_free_result"}, result_o, 64'd0);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      start_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      annul_i      = 1'b0;

      next_cycle();
      next_cycle();
      check("reset_ready", {63'd0, ready_o}, 64'd0);
      check("reset_result", result_o, 64'd0);
      check("reset_stall", {63'd0, stallreq_o}, 64'd0);
      rst = 1'b0;
      next_cycle();

      // DIVU 100 / 7 -> q=14, r=2
      do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);
      start_i = 1'b0;
      check_free("divu_100_7");

      // DIV -7 / 2 -> q=-3, r=-1
      do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
      start_i = 1'b0;
      check_free("div_m7_2");

      // DIV 7 / -2 -> q=-3, r=1
      do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
      start_i = 1'b0;
      check_free("div_7_m2");

      // DIV most-negative / -1 wraps
      do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33, 1'b0);
      start_i = 1'b0;
      check_free("div_ovf");

      // Same bits unsigned: q=0, r=dividend
      do_div("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 33, 1'b0);
      start_i = 1'b0;
      check_free("divu_big");

      // Divide by zero: END in C2 with zero result
      do_div("div_zero", 1'b1, 32'd55, 32'd0, 64'd0, 2, 1'b0);
      start_i = 1'b0;
      check_free("div_zero");

      // Back-to-back: next divide presented in END, started in the following FREE cycle
      do_div("b2b_first", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);
      opdata1_i = 32'd1000;
      opdata2_i = 32'd33;
      check_free("b2b_first");
      do_div("b2b_second", 1'b0, 32'd1000, 32'd33, 64'h0000000A_0000001E, 33, 1'b0);
      start_i = 1'b0;
      check_free("b2b_second");

      // Operands change mid-division; latched values must win
      do_div("scramble", 1'b0, 32'hFFFF_FFFF, 32'd16, 64'h0000000F_0FFFFFFF, 33, 1'b1);
      start_i = 1'b0;
      check_free("scramble");

      // Annul at iteration 10, then DIVU 9/3 from FREE
      start_i      = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = 32'hDEAD_BEEF;
      opdata2_i    = 32'd5;
      for (int i = 0; i < 11; i++) next_cycle();
      annul_i = 1'b1;
      #1;
      check("annul_stall", {63'd0, stallreq_o}, 64'd0);
      check("annul_ready", {63'd0, ready_o}, 64'd0);
      next_cycle();
      annul_i = 1'b0;
      check("annul_next_ready", {63'd0, ready_o}, 64'd0);
      check("annul_next_result", result_o, 64'd0);
      do_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);
      start_i = 1'b0;
      check_free("after_annul");

      // Annul beats start in FREE
      start_i   = 1'b1;
      annul_i   = 1'b1;
      opdata1_i = 32'd9;
      opdata2_i = 32'd3;
      #1;
      check("annul_free_stall", {63'd0, stallreq_o}, 64'd0);
      next_cycle();
      annul_i = 1'b0;
      do_div("annul_free_then", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);
      start_i = 1'b0;
      check_free("annul_free_then");

      // Reset at iteration 20 with start held; restart from cnt=0
      start_i      = 1'b1;
      signed_div_i = 1'b1;
      opdata1_i    = 32'hFFFF_FF9C;
      opdata2_i    = 32'd7;
      for (int i = 0; i < 21; i++) next_cycle();
      rst = 1'b1;
      next_cycle();
      check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
      check("rst_mid_result", result_o, 64'd0);
      rst = 1'b0;
      do_div("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33, 1'b0);
      start_i = 1'b0;
      check_free("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
